conv_spk_sched: RTL and testbench

Event scheduler directly upstream of the convolutional neuron cores. For each time step it scans the multi-channel input spike frame and, for every spiking input pixel, emits one synaptic event per kernel tap (affected output neuron row/col, filter phase, input channel), then triggers the activation pass once per output-channel phase. All `conv_nc` instances of a layer share its outputs.

---
 rtl/conv_spk_sched_if.sv | 36 +++
 rtl/conv_spk_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_spk_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_spk_sched_if.sv
// rtl/conv_spk_sched_if.sv - control/event bundle between the spike scheduler and its neuron cores
interface conv_spk_sched_if #(
    parameter int IN_CHANNELS       = 2,
    parameter int OUT_CHANNELS      = 4,
    parameter int KERNEL_SIZE       = 3,
    parameter int INPUT_FRAME_WIDTH = 28
) ();
    logic                                                     start;
    logic                                                     last_ts_in;
    logic [IN_CHANNELS*INPUT_FRAME_WIDTH*INPUT_FRAME_WIDTH-1:0] pre_syn_spk;
    logic                                                     en_accum;
    logic                                                     en_activ;
    logic                                                     last_time_step;
    logic [$clog2(IN_CHANNELS)+1:0]                           ic;
    logic                                                     ic_done;
    logic [$clog2(KERNEL_SIZE)+1:0]                           filter_phase;
    logic [$clog2(OUT_CHANNELS)+1:0]                          oc_phase;
    logic [$clog2(INPUT_FRAME_WIDTH)-1:0]                     affect_neur_addr_row;
    logic [$clog2(INPUT_FRAME_WIDTH)-1:0]                     affect_neur_addr_col;
    logic                                                     neur_addr_invalid;
    logic                                                     busy;
    logic                                                     done;
    logic [31:0]                                              spk_cnt;

    modport master (
        input  start, last_ts_in, pre_syn_spk,
        output en_accum, en_activ, last_time_step, ic, ic_done, filter_phase, oc_phase,
               affect_neur_addr_row, affect_neur_addr_col, neur_addr_invalid, busy, done, spk_cnt
    );

    modport slave (
        output start, last_ts_in, pre_syn_spk,
        input  en_accum, en_activ, last_time_step, ic, ic_done, filter_phase, oc_phase,
               affect_neur_addr_row, affect_neur_addr_col, neur_addr_invalid, busy, done, spk_cnt
    );
endinterface

// File: rtl/conv_spk_sched.sv
// rtl/conv_spk_sched.sv - per-time-step spike scan and synaptic event scheduler for conv neuron cores
module conv_spk_sched #(
    parameter int IN_CHANNELS        = 2,
    parameter int OUT_CHANNELS       = 4,
    parameter int EC_SIZE            = 2,
    parameter int KERNEL_SIZE        = 3,
    parameter int INPUT_FRAME_WIDTH  = 28,
    parameter int OUTPUT_FRAME_WIDTH = INPUT_FRAME_WIDTH - KERNEL_SIZE + 1
) (
    input logic              clk,
    input logic              rst,
    conv_spk_sched_if.master bus
);
    localparam int W         = INPUT_FRAME_WIDTH;
    localparam int K         = KERNEL_SIZE;
    localparam int O         = OUTPUT_FRAME_WIDTH;
    localparam int OC_PHASES = OUT_CHANNELS / EC_SIZE;
    localparam int WAIT_LEN  = O * O + 2;
    localparam int IC_W      = $clog2(IN_CHANNELS) + 2;
    localparam int FP_W      = $clog2(K) + 2;
    localparam int OC_W      = $clog2(OUT_CHANNELS) + 2;
    localparam int RW        = $clog2(W);
    localparam int KW        = (K > 1) ? $clog2(K) : 1;
    localparam int WC_W      = $clog2(WAIT_LEN);
    localparam int IDX_W     = $clog2(IN_CHANNELS * W * W);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PRIME   = 4'd1;
    localparam logic [3:0] S_SCAN    = 4'd2;
    localparam logic [3:0] S_EMIT    = 4'd3;
    localparam logic [3:0] S_BUBBLE  = 4'd4;
    localparam logic [3:0] S_IC_NEXT = 4'd5;
    localparam logic [3:0] S_ACTIV   = 4'd6;
    localparam logic [3:0] S_WAIT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]      state_q, state_d;
    logic [RW-1:0]   r_q, r_d, c_q, c_d;
    logic [KW-1:0]   kr_q, kr_d, kc_q, kc_d;
    logic [IC_W-1:0] ic_q, ic_d;
    logic [OC_W-1:0] oc_q, oc_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]     spk_cnt_q, spk_cnt_d;
    logic            lts_q, lts_d;

    logic            en_accum_q, en_accum_d;
    logic            en_activ_q, en_activ_d;
    logic            ic_done_q, ic_done_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            inv_q, inv_d;
    logic [FP_W-1:0] fp_q, fp_d;
    logic [RW-1:0]   row_q, row_d, col_q, col_d;

    logic [IDX_W-1:0] pix_idx;
    logic             spike_now, last_pix, col_wrap;
    logic [RW-1:0]    r_adv, c_adv;
    int               row_i, col_i;
    logic             tap_ok;

    assign pix_idx   = IDX_W'(ic_q) * IDX_W'(W * W) + IDX_W'(r_q) * IDX_W'(W) + IDX_W'(c_q);
    assign spike_now = bus.pre_syn_spk[pix_idx];
    assign col_wrap  = (c_q == RW'(W - 1));
    assign last_pix  = col_wrap && (r_q == RW'(W - 1));
    assign c_adv     = col_wrap ? '0 : c_q + RW'(1);
    assign r_adv     = col_wrap ? r_q + RW'(1) : r_q;

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        ic_d      = ic_q;
        oc_d      = oc_q;
        wcnt_d    = wcnt_q;
        spk_cnt_d = spk_cnt_q;
        lts_d     = lts_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lts_d     = bus.last_ts_in;
                    ic_d      = '0;
                    oc_d      = '0;
                    r_d       = '0;
                    c_d       = '0;
                    spk_cnt_d = '0;
                    state_d   = S_PRIME;
                end
            end
            S_PRIME: state_d = S_SCAN;
            S_SCAN: begin
                if (spike_now) begin
                    state_d = S_EMIT;
                    kr_d    = '0;
                    kc_d    = '0;
                    // later phases rescan the same frame; count each pixel once
                    if (oc_q == '0) spk_cnt_d = spk_cnt_q + 32'd1;
                end else if (last_pix) begin
                    state_d = S_IC_NEXT;
                end else begin
                    r_d = r_adv;
                    c_d = c_adv;
                end
            end
            S_EMIT: begin
                if (kr_q == KW'(K - 1) && kc_q == KW'(K - 1)) begin
                    state_d = S_BUBBLE;
                end else if (kc_q == KW'(K - 1)) begin
                    kc_d = '0;
                    kr_d = kr_q + KW'(1);
                end else begin
                    kc_d = kc_q + KW'(1);
                end
            end
            S_BUBBLE: begin
                if (last_pix) begin
                    state_d = S_IC_NEXT;
                end else begin
                    r_d     = r_adv;
                    c_d     = c_adv;
                    state_d = S_SCAN;
                end
            end
            S_IC_NEXT: begin
                r_d = '0;
                c_d = '0;
                if (ic_q < IC_W'(IN_CHANNELS - 1)) begin
                    ic_d    = ic_q + IC_W'(1);
                    state_d = S_SCAN;
                end else begin
                    state_d = S_ACTIV;
                end
            end
            S_ACTIV: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == WC_W'(WAIT_LEN - 1)) begin
                    if (oc_q < OC_W'(OC_PHASES - 1)) begin
                        oc_d    = oc_q + OC_W'(1);
                        ic_d    = '0;
                        state_d = S_PRIME;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        row_i      = int'(r_d) - int'(kr_d);
        col_i      = int'(c_d) - int'(kc_d);
        tap_ok     = (state_d == S_EMIT) && (row_i >= 0) && (col_i >= 0) && (row_i < O) && (col_i < O);
        inv_d      = !tap_ok;
        row_d      = tap_ok ? RW'(row_i) : '0;
        col_d      = tap_ok ? RW'(col_i) : '0;
        fp_d       = (state_d == S_EMIT) ? FP_W'(int'(kr_d) * K + int'(kc_d)) : '0;
        en_accum_d = state_d inside {S_PRIME, S_SCAN, S_EMIT, S_BUBBLE, S_IC_NEXT};
        en_activ_d = (state_d == S_ACTIV);
        ic_done_d  = (state_d == S_IC_NEXT);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            ic_q       <= '0;
            oc_q       <= '0;
            wcnt_q     <= '0;
            spk_cnt_q  <= '0;
            lts_q      <= 1'b0;
            en_accum_q <= 1'b0;
            en_activ_q <= 1'b0;
            ic_done_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            inv_q      <= 1'b1;
            fp_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            ic_q       <= ic_d;
            oc_q       <= oc_d;
            wcnt_q     <= wcnt_d;
            spk_cnt_q  <= spk_cnt_d;
            lts_q      <= lts_d;
            en_accum_q <= en_accum_d;
            en_activ_q <= en_activ_d;
            ic_done_q  <= ic_done_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            inv_q      <= inv_d;
            fp_q       <= fp_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    assign bus.en_accum             = en_accum_q;
    assign bus.en_activ             = en_activ_q;
    assign bus.last_time_step       = lts_q;
    assign bus.ic                   = ic_q;
    assign bus.ic_done              = ic_done_q;
    assign bus.filter_phase         = fp_q;
    assign bus.oc_phase             = oc_q;
    assign bus.affect_neur_addr_row = row_q;
    assign bus.affect_neur_addr_col = col_q;
    assign bus.neur_addr_invalid    = inv_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.spk_cnt              = spk_cnt_q;
endmodule

// File: tb/tb_conv_spk_sched.sv
// tb/tb_conv_spk_sched.sv - scoreboard bench for conv_spk_sched against a timeline model of a time step
module tb_conv_spk_sched;
    localparam int IC_N  = 2;
    localparam int W     = 28;
    localparam int K     = 3;
    localparam int O     = W - K + 1;
    localparam int PH    = 4 / 2;
    localparam int NPIX  = W * W;
    localparam int WAITC = O * O + 2;

    typedef struct {
        int cyc;
        bit bubble;
        bit inv;
        int fp;
        int row;
        int col;
        int ic;
        int oc;
    } tap_t;

    typedef struct {
        int cyc;
        int spk;
        bit lts;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_spk_sched_if #(.IN_CHANNELS(2), .OUT_CHANNELS(4), .KERNEL_SIZE(3), .INPUT_FRAME_WIDTH(28)) bus ();

    conv_spk_sched #(
        .IN_CHANNELS(2), .OUT_CHANNELS(4), .EC_SIZE(2), .KERNEL_SIZE(3),
        .INPUT_FRAME_WIDTH(28), .OUTPUT_FRAME_WIDTH(26)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    tap_t  exp_tap[$];
    int    exp_icd[$];
    int    exp_act[$];
    done_t exp_done[$];
    bit    frame[IC_N*NPIX];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, want);
        end
    endtask

    function automatic logic [63:0] out_pack();
        return {bus.en_accum, bus.en_activ, bus.ic_done, bus.done, bus.busy, bus.last_time_step,
                bus.neur_addr_invalid, 8'(bus.ic), 8'(bus.oc_phase), 8'(bus.filter_phase),
                8'(bus.affect_neur_addr_row), 8'(bus.affect_neur_addr_col), bus.spk_cnt[16:0]};
    endfunction

    // Walks the step as a timeline: each pixel costs one scan cycle, a spike adds K*K taps and a bubble.
    task automatic build_expect(input int base, input bit lts);
        int cur, spk, r, c, row, col;
        bit ok;
        spk = 0;
        cur = base + 1;
        for (int ph = 0; ph < PH; ph++) begin
            cur += 1;
            for (int ch = 0; ch < IC_N; ch++) begin
                for (int p = 0; p < NPIX; p++) begin
                    r = p / W;
                    c = p % W;
                    if (frame[ch*NPIX+p]) begin
                        if (ph == 0) spk++;
                        for (int t = 0; t < K * K; t++) begin
                            row = r - t / K;
                            col = c - t % K;
                            ok  = row >= 0 && row < O && col >= 0 && col < O;
                            exp_tap.push_back('{cur + 1 + t, 1'b0, !ok, t, ok ? row : 0, ok ? col : 0, ch, ph});
                        end
                        exp_tap.push_back('{cur + K * K + 1, 1'b1, 1'b1, 0, 0, 0, ch, ph});
                        cur += K * K + 2;
                    end else begin
                        cur += 1;
                    end
                end
                exp_icd.push_back(cur);
                cur += 1;
            end
            exp_act.push_back(cur);
            cur += 1 + WAITC;
        end
        exp_done.push_back('{cur, spk, lts});
    endtask

    tap_t        e;
    done_t       d;
    int          wc;
    logic [63:0] a, w;

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_tap.size() > 0 && exp_tap[0].cyc == cyc) begin
                e = exp_tap.pop_front();
                if (e.bubble) begin
                    a = {62'd0, bus.en_accum, bus.neur_addr_invalid};
                    w = 64'd3;
                    chk("bubble", a == w, a, w);
                end else begin
                    a = {22'd0, bus.en_accum, bus.neur_addr_invalid, 8'(bus.filter_phase),
                         8'(bus.affect_neur_addr_row), 8'(bus.affect_neur_addr_col), 8'(bus.ic), 8'(bus.oc_phase)};
                    w = {22'd0, 1'b1, e.inv, 8'(e.fp), 8'(e.row), 8'(e.col), 8'(e.ic), 8'(e.oc)};
                    chk("tap", a == w, a, w);
                end
            end else begin
                chk("no_event", !(bus.en_accum && !bus.neur_addr_invalid), 64'(cyc), 64'd0);
            end
            chk("addr_range", bus.affect_neur_addr_row < O && bus.affect_neur_addr_col < O,
                {32'(bus.affect_neur_addr_row), 32'(bus.affect_neur_addr_col)}, 64'(O));
            if (bus.ic_done) begin
                wc = (exp_icd.size() > 0) ? exp_icd.pop_front() : -1;
                chk("ic_done_cyc", cyc == wc, 64'(cyc), 64'(wc));
            end
            if (bus.en_activ) begin
                wc = (exp_act.size() > 0) ? exp_act.pop_front() : -1;
                chk("en_activ_cyc", cyc == wc && !bus.en_accum, 64'(cyc), 64'(wc));
            end
            if (bus.done) begin
                d = (exp_done.size() > 0) ? exp_done.pop_front() : '{-1, 0, 1'b0};
                a = {24'(cyc), bus.spk_cnt, 8'(bus.last_time_step)};
                w = {24'(d.cyc), 32'(d.spk), 8'(d.lts)};
                chk("done", a == w, a, w);
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < IC_N * NPIX; i++) frame[i] = 1'b0;
    endtask

    task automatic load_frame();
        for (int i = 0; i < IC_N * NPIX; i++) bus.pre_syn_spk[i] = frame[i];
    endtask

    task automatic kick(input bit lts);
        @(negedge clk);
        #1;
        load_frame();
        bus.last_ts_in = lts;
        bus.start      = 1'b1;
        build_expect(cyc, lts);
        @(negedge clk);
        #1;
        bus.start      = 1'b0;
        bus.last_ts_in = 1'b0;
    endtask

    task automatic run_step(input bit lts, input int restart_at);
        int n;
        kick(lts);
        n = 0;
        while (exp_done.size() > 0 && n < 8000) begin
            @(negedge clk);
            #1;
            n++;
            if (n == restart_at) begin
                bus.start      = 1'b1;
                bus.last_ts_in = 1'b1;
                @(negedge clk);
                #1;
                bus.start      = 1'b0;
                bus.last_ts_in = 1'b0;
                n++;
            end
        end
        chk("step_finished", exp_done.size() == 0, 64'(exp_done.size()), 64'd0);
        chk("taps_drained", exp_tap.size() == 0, 64'(exp_tap.size()), 64'd0);
        chk("pulses_drained", exp_icd.size() + exp_act.size() == 0, 64'(exp_icd.size() + exp_act.size()), 64'd0);
        exp_done.delete();
        exp_tap.delete();
        exp_icd.delete();
        exp_act.delete();
        @(negedge clk);
        #1;
        chk("idle_after", !bus.busy && !bus.en_accum, {62'd0, bus.busy, bus.en_accum}, 64'd0);
    endtask

    task automatic random_frame();
        clear_frame();
        for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            frame[$urandom_range(0, IC_N - 1) * NPIX + $urandom_range(0, W - 1) * W + $urandom_range(0, W - 1)] = 1'b1;
    endtask

    localparam logic [63:0] RESET_PACK = {7'b0000001, 40'd0, 17'd0};

    initial begin
        bit found;
        bus.start       = 1'b0;
        bus.last_ts_in  = 1'b0;
        bus.pre_syn_spk = '0;
        clear_frame();
        repeat (3) @(negedge clk);
        chk("reset_values", out_pack() == RESET_PACK, out_pack(), RESET_PACK);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_values", out_pack() == RESET_PACK, out_pack(), RESET_PACK);

        run_step(1'b0, -1);

        clear_frame();
        frame[1*NPIX + 5*W + 7] = 1'b1;
        run_step(1'b1, -1);

        clear_frame();
        frame[0*NPIX + 0*W + 0] = 1'b1;
        frame[1*NPIX + 27*W + 27] = 1'b1;
        run_step(1'b0, -1);

        clear_frame();
        frame[0*NPIX + 2*W + 2] = 1'b1;
        frame[0*NPIX + 2*W + 3] = 1'b1;
        run_step(1'b0, -1);

        clear_frame();
        frame[0*NPIX + 3*W + 4] = 1'b1;
        kick(1'b1);
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            #1;
            found = bus.en_accum && !bus.neur_addr_invalid;
        end
        chk("emit_reached", found, 64'(found), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", out_pack() == RESET_PACK, out_pack(), RESET_PACK);
        exp_tap.delete();
        exp_icd.delete();
        exp_act.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        random_frame();
        run_step(1'b0, -1);

        random_frame();
        run_step(1'b0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
